// File: rtl/uart_fifo_bridge.sv
// 8N1 UART with byte FIFOs on both directions, core-facing show-ahead RX.
// Define UART_LOOPBACK_EN to feed the receiver from txd instead of rxd.
module uart_fifo_bridge #(
  parameter int CLK_PER_BIT = 434,
  parameter int FIFO_AW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       uart_rdreq,
  output logic       uart_empty,
  output logic [7:0] uart_in,
  input  logic       uart_wrreq,
  input  logic [7:0] uart_out,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_t;

  logic rx_line;
`ifdef UART_LOOPBACK_EN
  assign rx_line = txd;
`else
  assign rx_line = rxd;
`endif

  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_line;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  st_t         rx_st;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_fall;
  logic        rx_push;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_push = (rx_st == S_STOP) &&
                   (rx_cnt == BIT_LAST) && rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (rx_st)
        S_IDLE: begin
          if (rx_fall) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt    <= '0;
            rx_st     <= S_IDLE;
            frame_err <= ~rx_s2;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wp;
  logic [FIFO_AW:0] rx_rp;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_pop;
  logic             rx_wr;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
  assign rx_pop   = uart_rdreq & ~rx_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign rx_wr    = rx_push & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_wr) rx_overrun <= 1'b1;
    end
  end

  assign uart_empty = rx_empty;
  assign uart_in    = rx_empty ? 8'h00 :
                      rx_mem[rx_rp[FIFO_AW-1:0]];

  logic [7:0]       tx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp;
  logic [FIFO_AW:0] tx_rp;
  logic             tx_empty;
  logic             tx_load;
  logic             tx_wr;
  st_t              tx_st;
  logic [15:0]      tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  // Chain straight from stop into the next start when data is waiting.
  assign tx_load  = ~tx_empty &
                    ((tx_st == S_IDLE) ||
                     (tx_st == S_STOP && tx_cnt == BIT_LAST));
  assign tx_wr    = uart_wrreq & (~tx_full | tx_load);
  assign tx_busy  = (tx_st != S_IDLE) | ~tx_empty;

  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp[FIFO_AW-1:0]] <= uart_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_wr)   tx_wp <= tx_wp + 1'b1;
      if (tx_load) tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txd    <= 1'b1;
    end else if (tx_load) begin
      tx_st  <= S_START;
      tx_cnt <= '0;
      tx_sh  <= tx_mem[tx_rp[FIFO_AW-1:0]];
      txd    <= 1'b0;
    end else begin
      unique case (tx_st)
        S_IDLE: begin
          txd <= 1'b1;
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_st  <= S_DATA;
            txd    <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx_st <= S_STOP;
              txd   <= 1'b1;
            end else begin
              txd   <= tx_sh[0];
              tx_sh <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_st  <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge: TX framing, reset abort, RX,
// framing error, glitch rejection, overrun and TX FIFO full.
module tb_uart_fifo_bridge;
  localparam int CPB = 8;
  localparam int AW  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       uart_rdreq = 1'b0;
  logic       uart_wrreq = 1'b0;
  logic [7:0] uart_out = 8'h00;
  logic       txd;
  logic       uart_empty;
  logic [7:0] uart_in;
  logic       tx_full;
  logic       tx_busy;
  logic       rx_overrun;
  logic       frame_err;

  uart_fifo_bridge #(
    .CLK_PER_BIT(CPB),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .txd(txd),
    .uart_rdreq(uart_rdreq),
    .uart_empty(uart_empty),
    .uart_in(uart_in),
    .uart_wrreq(uart_wrreq),
    .uart_out(uart_out),
    .tx_full(tx_full),
    .tx_busy(tx_busy),
    .rx_overrun(rx_overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] exp5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(logic [7:0] d);
    uart_out   = d;
    uart_wrreq = 1'b1;
    tick(1);
    uart_wrreq = 1'b0;
  endtask

  task automatic pop_rx();
    uart_rdreq = 1'b1;
    tick(1);
    uart_rdreq = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] d, logic stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  // Independent serial decoder on txd, sampling near bit centres.
  initial begin : dec
    logic [7:0] b;
    logic       bad;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (rst) bad = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
          for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rst) bad = 1'b1;
          end
          b[k] = txd;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (rst) bad = 1'b1;
        end
        if (!bad) txq.push_back(b);
      end
    end
  end

  initial begin
    logic [9:0] fr;
    int         fe0;
    int         t;

    rst = 1'b1;
    tick(2);
    chk("rst_txd", txd, 1);
    chk("rst_empty", uart_empty, 1);
    chk("rst_in", uart_in, 8'h00);
    chk("rst_full", tx_full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(1);

`ifndef UART_LOOPBACK_EN
    push_tx(8'h55);
    fr = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        tick(1);
        chk("tx55_bit", txd, fr[b]);
      end
    end
    chk("tx55_busy_stop", tx_busy, 1);
    tick(1);
    chk("tx55_busy_end", tx_busy, 0);
    chk("tx55_qsize", txq.size(), 1);
    chk("tx55_byte", (txq.size() > 0) ? txq[0] : 8'hxx, 8'h55);
    txq.delete();

    push_tx(8'hA5);
    tick(20);
    rst = 1'b1;
    tick(2);
    chk("rstmid_txd", txd, 1);
    chk("rstmid_empty", uart_empty, 1);
    chk("rstmid_busy", tx_busy, 0);
    rst = 1'b0;
    tick(1);
    chk("rstmid_txd2", txd, 1);
    chk("rstmid_busy2", tx_busy, 0);
    tick(100);
    chk("rstmid_noframe", txq.size(), 0);

    send_rx(8'hC3, 1'b1);
    chk("rxc3_empty", uart_empty, 0);
    chk("rxc3_data", uart_in, 8'hC3);
    pop_rx();
    chk("rxc3_popped", uart_empty, 1);
    chk("rxc3_in0", uart_in, 8'h00);
    chk("rxc3_noferr", fe_cnt, 0);

    tick(4);
    fe0 = fe_cnt;
    send_rx(8'hFF, 1'b0);
    tick(4);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_low", frame_err, 0);
    chk("ferr_nopush", uart_empty, 1);

    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(100);
    chk("glitch_empty", uart_empty, 1);
    chk("glitch_noferr", fe_cnt - fe0, 1);

    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("ovr_before", rx_overrun, 0);
      send_rx(8'(i), 1'b1);
      tick(2);
    end
    chk("ovr_set", rx_overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_nonempty", uart_empty, 0);
      chk("ovr_data", uart_in, i);
      pop_rx();
    end
    chk("ovr_drained", uart_empty, 1);
    chk("ovr_sticky", rx_overrun, 1);

    txq.delete();
    uart_wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      uart_out = exp5[i];
      tick(1);
    end
    chk("txfull_set", tx_full, 1);
    uart_out = 8'h66;
    tick(1);
    uart_wrreq = 1'b0;
    chk("txfull_hold", tx_full, 1);
    t = 0;
    while (tx_busy && t < 2000) begin
      tick(1);
      t++;
    end
    chk("txfull_drain", t < 2000, 1);
    tick(2);
    chk("txfull_qsize", txq.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("txfull_byte", (i < txq.size()) ? txq[i] : 8'hxx,
          exp5[i]);
`else
    rxd = 1'b0;
    push_tx(8'h3C);
    push_tx(8'h7E);
    t = 0;
    while (uart_empty && t < 2000) begin
      tick(1);
      t++;
    end
    chk("lb_first_wait", t < 2000, 1);
    chk("lb_first", uart_in, 8'h3C);
    pop_rx();
    t = 0;
    while (uart_empty && t < 2000) begin
      tick(1);
      t++;
    end
    chk("lb_second_wait", t < 2000, 1);
    chk("lb_second", uart_in, 8'h7E);
    pop_rx();
    chk("lb_drained", uart_empty, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
